// File: rtl/fire_vote_if.sv
`timescale 1ns/1ps
// Sample/vote bus between the sensor front end and fire_vote_detector.
// The event_time signal exists only when FIRE_VOTE_TIMESTAMP_EN is defined.
interface fire_vote_if #(
    parameter int N_SENSORS = 3,
    parameter int CNT_W     = 8
`ifdef FIRE_VOTE_TIMESTAMP_EN
    , parameter int TS_W    = 16
`endif
);
    logic                 sample_valid;
    logic [N_SENSORS-1:0] sensor;
    logic                 clear_faults;
    logic                 event_out;
    logic                 event_pulse;
    logic [N_SENSORS-1:0] flag;
    logic [N_SENSORS-1:0] fault_mask;
    logic [CNT_W-1:0]     event_count;
`ifdef FIRE_VOTE_TIMESTAMP_EN
    logic [TS_W-1:0]      event_time;
`endif

    modport master (
        output sample_valid, sensor, clear_faults,
        input  event_out, event_pulse, flag, fault_mask, event_count
`ifdef FIRE_VOTE_TIMESTAMP_EN
        , event_time
`endif
    );

    modport slave (
        input  sample_valid, sensor, clear_faults,
        output event_out, event_pulse, flag, fault_mask, event_count
`ifdef FIRE_VOTE_TIMESTAMP_EN
        , event_time
`endif
    );
endinterface

// File: rtl/fire_vote_detector.sv
`timescale 1ns/1ps
// N-channel fire voter: confirms events after HOLD_SAMPLES agreeing samples and masks lone-firing channels.
// Define FIRE_VOTE_TIMESTAMP_EN to add a free-running cycle counter and the event_time output.
module fire_vote_detector #(
    parameter int N_SENSORS    = 3,
    parameter int VOTE_MIN     = 3,
    parameter int HOLD_SAMPLES = 2,
    parameter int FAULT_LIMIT  = 3,
    parameter int CNT_W        = 8
`ifdef FIRE_VOTE_TIMESTAMP_EN
    , parameter int TS_W       = 16
`endif
) (
    input logic        clk,
    input logic        rst,
    fire_vote_if.slave bus
);
    localparam int CW = $clog2(N_SENSORS + 1);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int SW = $clog2(FAULT_LIMIT + 1);

    localparam logic [CW-1:0] VOTE_MIN_C  = CW'(VOTE_MIN);
    localparam logic [CW-1:0] N_C         = CW'(N_SENSORS);
    localparam logic [HW-1:0] HOLD_LAST_C = HW'(HOLD_SAMPLES - 1);
    localparam logic [SW-1:0] LIMIT_C     = SW'(FAULT_LIMIT);

    typedef enum logic [1:0] {IDLE, PENDING, ALARM} state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [SW-1:0]        strike_q [N_SENSORS];
    logic [N_SENSORS-1:0] mask_q;
    logic [N_SENSORS-1:0] flag_q;
    logic                 event_out_q;
    logic                 event_pulse_q;
    logic [CNT_W-1:0]     count_q;

    logic [N_SENSORS-1:0] active;
    logic [CW-1:0]        votes;
    logic [CW-1:0]        healthy;
    logic [CW-1:0]        thr;
    logic                 qualify;
    logic                 alarm_entry;
    logic                 strike_en;

    function automatic logic [CW-1:0] popcnt(input logic [N_SENSORS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < N_SENSORS; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    assign active  = bus.sensor & ~mask_q;
    assign votes   = popcnt(active);
    assign healthy = N_C - popcnt(mask_q);
    assign thr     = (VOTE_MIN_C < healthy) ? VOTE_MIN_C : healthy;
    assign qualify = (thr != '0) && (votes >= thr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        hold_d      = hold_q;
        alarm_entry = 1'b0;
        strike_en   = 1'b0;
        if (bus.sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (qualify) begin
                        if (HOLD_SAMPLES == 1) begin
                            alarm_entry = 1'b1;
                        end else begin
                            state_d = PENDING;
                            hold_d  = HW'(1);
                        end
                    end else if (votes == CW'(1) && thr > CW'(1)) begin
                        strike_en = 1'b1;
                    end
                end
                PENDING: begin
                    if (qualify) begin
                        if (hold_q == HOLD_LAST_C) alarm_entry = 1'b1;
                        else                       hold_d      = hold_q + HW'(1);
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                ALARM: begin
                    if (!qualify) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (alarm_entry) begin
                state_d = ALARM;
                hold_d  = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            flag_q        <= '0;
            event_out_q   <= 1'b0;
            event_pulse_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            event_out_q   <= (state_d == ALARM);
            event_pulse_q <= alarm_entry;
            if (bus.sample_valid) flag_q <= active;
            if (alarm_entry && count_q != '1) count_q <= count_q + CNT_W'(1);
        end
    end

    // NOTE: the strike array is small and must start from zero after reset, so it is reset like plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) strike_q[i] <= '0;
        end else if (bus.clear_faults) begin
            mask_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) strike_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (alarm_entry && active[i]) begin
                    strike_q[i] <= '0;
                end else if (strike_en && active[i] && strike_q[i] != LIMIT_C) begin
                    strike_q[i] <= strike_q[i] + SW'(1);
                    if (strike_q[i] == LIMIT_C - SW'(1)) mask_q[i] <= 1'b1;
                end
            end
        end
    end

`ifdef FIRE_VOTE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] event_time_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= '0;
            event_time_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (alarm_entry) event_time_q <= ts_q;
        end
    end

    assign bus.event_time = event_time_q;
`endif

    assign bus.event_out   = event_out_q;
    assign bus.event_pulse = event_pulse_q;
    assign bus.flag        = flag_q;
    assign bus.fault_mask  = mask_q;
    assign bus.event_count = count_q;
endmodule

// File: tb/tb_fire_vote_detector.sv
`timescale 1ns/1ps
// Scoreboard bench for fire_vote_detector: a behavioural model pushes expected outputs
// for every driven cycle; they are popped and compared one cycle later.
module tb_fire_vote_detector;
    localparam int N  = 3;
    localparam int VM = 3;
    localparam int HS = 2;
    localparam int FL = 3;
    localparam int CW = 8;

    typedef struct {
        logic          out;
        logic          pulse;
        logic [N-1:0]  flag;
        logic [N-1:0]  mask;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fire_vote_if #(.N_SENSORS(N), .CNT_W(CW)) bus();

    fire_vote_detector #(
        .N_SENSORS(N), .VOTE_MIN(VM), .HOLD_SAMPLES(HS), .FAULT_LIMIT(FL), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    int            m_state;
    int            m_hold;
    int            m_strike [N];
    logic [N-1:0]  m_mask, m_flag;
    logic          m_pulse, m_out;
    logic [CW-1:0] m_count;

    task automatic model_step(input logic r, input logic sv, input logic [N-1:0] s, input logic cf);
        logic [N-1:0] act;
        int nv, nh, th, lone;
        bit q, entry;
        if (r) begin
            m_state = 0; m_hold = 0; m_mask = '0; m_flag = '0;
            m_pulse = 1'b0; m_out = 1'b0; m_count = '0;
            for (int i = 0; i < N; i++) m_strike[i] = 0;
            return;
        end
        m_pulse = 1'b0;
        entry   = 1'b0;
        lone    = 0;
        if (sv) begin
            act = s & ~m_mask;
            nv  = $countones(act);
            nh  = N - $countones(m_mask);
            th  = (VM < nh) ? VM : nh;
            q   = (th > 0) && (nv >= th);
            m_flag = act;
            if (m_state == 0) begin
                if (q) begin
                    if (HS == 1) entry = 1'b1;
                    else begin m_state = 1; m_hold = 1; end
                end else if (nv == 1 && th > 1) begin
                    for (int i = 0; i < N; i++) if (act[i]) lone = i;
                    if (m_strike[lone] < FL) m_strike[lone]++;
                    if (m_strike[lone] == FL) m_mask[lone] = 1'b1;
                end
            end else if (m_state == 1) begin
                if (q) begin
                    m_hold++;
                    if (m_hold >= HS) entry = 1'b1;
                end else begin
                    m_state = 0; m_hold = 0;
                end
            end else if (!q) begin
                m_state = 0;
            end
            if (entry) begin
                m_state = 2; m_hold = 0; m_pulse = 1'b1;
                if (m_count != '1) m_count++;
                for (int i = 0; i < N; i++) if (act[i]) m_strike[i] = 0;
            end
        end
        if (cf) begin
            m_mask = '0;
            for (int i = 0; i < N; i++) m_strike[i] = 0;
        end
        m_out = (m_state == 2);
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic sv,
                         input logic [N-1:0] s, input logic cf);
        exp_t e;
        rst              = r;
        bus.sample_valid = sv;
        bus.sensor       = s;
        bus.clear_faults = cf;
        model_step(r, sv, s, cf);
        e.out = m_out; e.pulse = m_pulse; e.flag = m_flag; e.mask = m_mask; e.cnt = m_count;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count} !==
            {e.out, e.pulse, e.flag, e.mask, e.cnt}) begin
            errors++;
            $display("FAIL %s: got out=%b pulse=%b flag=%b mask=%b cnt=%0d, expected out=%b pulse=%b flag=%b mask=%b cnt=%0d",
                     tag, bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count,
                     e.out, e.pulse, e.flag, e.mask, e.cnt);
        end
        rst              = 1'b0;
        bus.clear_faults = 1'b0;
    endtask

    task automatic test_reset();
        cycle("reset", 1'b1, 1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 10; i++) cycle("idle_zero", 1'b0, 1'b1, 3'b000, 1'b0);
        checks++;
        if ({bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count});
        end
    endtask

    task automatic test_event();
        cycle("ev_s1", 1'b0, 1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.event_pulse !== 1'b0) begin
            errors++; $display("FAIL ev_early_pulse: got %b, expected 0", bus.event_pulse);
        end
        cycle("ev_s2", 1'b0, 1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.event_pulse !== 1'b1 || bus.event_out !== 1'b1 || bus.event_count !== 8'd1) begin
            errors++;
            $display("FAIL ev_confirm: got pulse=%b out=%b cnt=%0d, expected 1 1 1",
                     bus.event_pulse, bus.event_out, bus.event_count);
        end
        cycle("ev_s3", 1'b0, 1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.event_pulse !== 1'b0 || bus.event_out !== 1'b1 || bus.flag !== 3'b111) begin
            errors++;
            $display("FAIL ev_hold: got pulse=%b out=%b flag=%b, expected 0 1 111",
                     bus.event_pulse, bus.event_out, bus.flag);
        end
        cycle("ev_exit", 1'b0, 1'b1, 3'b000, 1'b0);
        checks++;
        if (bus.event_out !== 1'b0 || bus.flag !== 3'b000) begin
            errors++;
            $display("FAIL ev_exit: got out=%b flag=%b, expected 0 000", bus.event_out, bus.flag);
        end
    endtask

    task automatic test_short_burst();
        cycle("short_s1", 1'b0, 1'b1, 3'b111, 1'b0);
        cycle("short_s2", 1'b0, 1'b1, 3'b000, 1'b0);
        cycle("short_idle", 1'b0, 1'b0, 3'b111, 1'b0);
        checks++;
        if (bus.event_count !== 8'd1 || bus.event_out !== 1'b0 || bus.fault_mask !== 3'b000) begin
            errors++;
            $display("FAIL short_no_event: got cnt=%0d out=%b mask=%b, expected 1 0 000",
                     bus.event_count, bus.event_out, bus.fault_mask);
        end
    endtask

    task automatic test_fault_mask();
        for (int i = 0; i < 3; i++) begin
            cycle("hum_lone", 1'b0, 1'b1, 3'b100, 1'b0);
            cycle("hum_gap", 1'b0, 1'b1, 3'b000, 1'b0);
        end
        checks++;
        if (bus.fault_mask !== 3'b100) begin
            errors++; $display("FAIL hum_masked: got mask=%b, expected 100", bus.fault_mask);
        end
        cycle("deg_s1", 1'b0, 1'b1, 3'b011, 1'b0);
        cycle("deg_s2", 1'b0, 1'b1, 3'b011, 1'b0);
        checks++;
        if (bus.event_pulse !== 1'b1 || bus.event_count !== 8'd2) begin
            errors++;
            $display("FAIL deg_event: got pulse=%b cnt=%0d, expected 1 2", bus.event_pulse, bus.event_count);
        end
        cycle("deg_exit", 1'b0, 1'b1, 3'b000, 1'b0);
        cycle("deg_clear", 1'b0, 1'b1, 3'b000, 1'b1);
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < 2; i++) begin
            cycle("clr_lone", 1'b0, 1'b1, 3'b100, 1'b0);
            cycle("clr_gap", 1'b0, 1'b1, 3'b000, 1'b0);
        end
        cycle("clr_third", 1'b0, 1'b1, 3'b100, 1'b1);
        checks++;
        if (bus.fault_mask !== 3'b000) begin
            errors++; $display("FAIL clr_wins: got mask=%b, expected 000", bus.fault_mask);
        end
        for (int i = 0; i < 2; i++) begin
            cycle("clr_gap2", 1'b0, 1'b1, 3'b000, 1'b0);
            cycle("clr_relone", 1'b0, 1'b1, 3'b100, 1'b0);
        end
        checks++;
        if (bus.fault_mask !== 3'b000) begin
            errors++; $display("FAIL clr_restart: got mask=%b, expected 000", bus.fault_mask);
        end
        cycle("clr_gap3", 1'b0, 1'b1, 3'b000, 1'b0);
        cycle("clr_final", 1'b0, 1'b1, 3'b100, 1'b0);
        checks++;
        if (bus.fault_mask !== 3'b100) begin
            errors++; $display("FAIL clr_remask: got mask=%b, expected 100", bus.fault_mask);
        end
        cycle("clr_reset_mask", 1'b0, 1'b1, 3'b000, 1'b1);
    endtask

    task automatic test_saturation();
        while (m_count < 8'd255) begin
            cycle("sat_s1", 1'b0, 1'b1, 3'b111, 1'b0);
            cycle("sat_s2", 1'b0, 1'b1, 3'b111, 1'b0);
            cycle("sat_exit", 1'b0, 1'b1, 3'b000, 1'b0);
        end
        cycle("sat_last1", 1'b0, 1'b1, 3'b111, 1'b0);
        cycle("sat_last2", 1'b0, 1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.event_count !== 8'd255 || bus.event_pulse !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: got cnt=%0d pulse=%b, expected 255 1", bus.event_count, bus.event_pulse);
        end
        cycle("sat_exit2", 1'b0, 1'b1, 3'b000, 1'b0);
    endtask

    task automatic test_reset_pending();
        cycle("rp_pend", 1'b0, 1'b1, 3'b111, 1'b0);
        cycle("rp_rst", 1'b1, 1'b1, 3'b111, 1'b0);
        checks++;
        if ({bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count} !== '0) begin
            errors++;
            $display("FAIL rp_zero: got %b, expected all zero",
                     {bus.event_out, bus.event_pulse, bus.flag, bus.fault_mask, bus.event_count});
        end
        cycle("rp_after", 1'b0, 1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.event_pulse !== 1'b0) begin
            errors++; $display("FAIL rp_idle: got pulse=%b, expected 0", bus.event_pulse);
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sensor       = '0;
        bus.clear_faults = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_event();
        test_short_burst();
        test_fault_mask();
        test_clear_collision();
        test_saturation();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fire_vote_detector.md
Name: fire_vote_detector

Overview:
- Parametrised successor to the three-sensor fire comparator.
- Takes N binary sensor channels and requires a configurable number of healthy channels to agree for a configurable number of consecutive samples before declaring a trustworthy event.
- Tracks lone-channel assertions per channel and masks channels that repeatedly fire alone as faulty.
- Sits between the sensor sampling front end and the alarm/report logic; counts confirmed events.

Parameters:
- N_SENSORS, 3, number of sensor channels (2..16).
- VOTE_MIN, 3, agreeing healthy channels needed for an event (1..N_SENSORS).
- HOLD_SAMPLES, 2, consecutive qualifying samples before an event is confirmed (>=1).
- FAULT_LIMIT, 3, lone-assertion strikes before a channel is masked (>=1).
- CNT_W, 8, width of the event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sample_valid  in  1  sensor is sampled on this cycle.
- sensor  in  N_SENSORS  raw sensor levels; bit0=Temperature, bit1=Smoke, bit2=Humidity by convention.
- clear_faults  in  1  one-cycle pulse; clears fault_mask and all strike counters.
- event_out  out  1  high while in ALARM.
- event_pulse  out  1  one-cycle pulse on ALARM entry.
- flag  out  N_SENSORS  healthy-active pattern of the last valid sample.
- fault_mask  out  N_SENSORS  1 = channel masked as faulty.
- event_count  out  CNT_W  confirmed events, saturating.

Behaviour:
- All outputs are registered. Reset values: every output is 0; state is IDLE; hold counter and all strike counters are 0. rst overrides every other input, including sample_valid.
- All logic acts only on cycles with sample_valid=1. Otherwise state, counters and flag hold, and event_pulse is 0.
- active = sensor & ~fault_mask; votes = popcount(active).
- healthy = N_SENSORS - popcount(fault_mask); thr = min(VOTE_MIN, healthy).
- qualify = (thr>0) && (votes>=thr). If all channels are masked, qualify=0.
- flag <= active, visible the cycle after the sample.
- IDLE:
  - qualify: if HOLD_SAMPLES==1, go to ALARM; else go to PENDING with hold=1.
  - !qualify and votes==1 and thr>1: increment the strike counter of the single active channel. When that counter reaches FAULT_LIMIT, set its fault_mask bit. The mask takes effect from the next sample.
- PENDING:
  - qualify: hold++. When hold reaches HOLD_SAMPLES, go to ALARM.
  - !qualify: return to IDLE and clear hold. No strikes are charged in PENDING.
- ALARM entry:
  - event_pulse=1 for exactly one cycle, after the edge that registers the confirming sample.
  - event_count += 1, saturating at all-ones.
  - Strike counters of the channels active in the confirming sample are cleared.
- ALARM:
  - event_out=1.
  - On a valid sample with !qualify, go to IDLE (event_out falls with that sample).
  - No strikes are charged in ALARM.
- clear_faults: clears fault_mask and strikes the same cycle and wins over a simultaneous strike or mask set. The FSM and event_count are unaffected.
- If a mask update lowers thr mid-PENDING, the new thr applies from the next sample. hold is not reset.
- Strike counters saturate at FAULT_LIMIT.

Optional Feature:
- Macro: FIRE_VOTE_TIMESTAMP_EN.
- When defined:
  - Adds a free-running TS_W-bit (parameter, default 16) cycle counter, reset to 0 and wrapping.
  - Adds output event_time [TS_W], which latches the counter value on the event_pulse cycle and holds until the next event. Reset value is 0.
- When undefined: neither the port nor the counter exists, and all other behaviour is identical.

Test Plan:
(all with N=3, VOTE_MIN=3, HOLD_SAMPLES=2, FAULT_LIMIT=3, sample_valid every cycle)
- Reset, then sensor=000 for 10 cycles -> all outputs 0, state IDLE.
- sensor=111 for 3 samples, then 000 -> event_pulse exactly once, after the 2nd sample; event_out high until the 000 sample; event_count=1; flag=111 then 000.
- sensor=111 for 1 sample, then 000 -> no event; event_count unchanged; no strikes charged.
- Humidity alone (100 on bit2) for 3 isolated samples -> fault_mask=100 after the 3rd; then sensor=011 for 2 samples -> thr=2, event confirmed, event_count increments.
- clear_faults pulsed in the same cycle as a 3rd lone strike -> fault_mask stays 000; a following lone sample gives strike count 1.
- Force event_count to 255 via 255 events, then one more event -> event_count stays 255 and event_pulse still fires.
- rst asserted mid-PENDING with sample_valid=1 and sensor=111 -> next cycle all outputs 0, state IDLE.
